// File: rtl/dlx_instr_packer.sv
// rtl/dlx_instr_packer.sv - packs DLX instruction fields into words and streams them to instruction memory
// Optional opcode/format consistency check is enabled by defining PACKER_FMT_CHECK_EN.
module dlx_instr_packer #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [0:31] i_start_addr,
    input  logic        i_stop,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [0:1]  i_fmt,
    input  logic [0:5]  i_opcode,
    input  logic [0:4]  i_rs1,
    input  logic [0:4]  i_rs2,
    input  logic [0:4]  i_rd,
    input  logic [0:5]  i_func,
    input  logic [0:25] i_imm26,
    output logic        o_mem_we,
    input  logic        i_mem_ready,
    output logic [0:31] o_mem_addr,
    output logic [0:31] o_mem_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [0:15] o_count,
    output logic        o_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t      r_state;
    logic [0:31] r_fifo [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [0:31] r_addr;
    logic [0:15] r_count;
    logic        r_err;
    logic        r_done;

    logic        w_empty;
    logic        w_full;
    logic        w_in_ready;
    logic        w_mem_we;
    logic        w_accept;
    logic        w_violation;
    logic        w_push;
    logic        w_pop;
    logic [0:31] w_word;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_in_ready = (r_state == S_RUN) && !w_full;
    assign w_mem_we   = (r_state != S_IDLE) && !w_empty;
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_push     = w_accept && !w_violation;
    assign w_pop      = w_mem_we && i_mem_ready;

`ifdef PACKER_FMT_CHECK_EN
    always_comb begin
        w_violation = 1'b0;
        case (i_fmt)
            2'b00:   w_violation = (i_opcode != 6'b000000);
            2'b01:   w_violation = (i_opcode != 6'b000001);
            default: w_violation = (i_opcode == 6'b000000) || (i_opcode == 6'b000001);
        endcase
    end
`else
    assign w_violation = 1'b0;
`endif

    // R and FP R-type opcodes are fixed by the format, not taken from i_opcode.
    always_comb begin
        w_word = '0;
        case (i_fmt)
            2'b00:   w_word = {6'b000000, i_rs1, i_rs2, i_rd, 5'b00000, i_func};
            2'b01:   w_word = {6'b000001, i_rs1, i_rs2, i_rd, 6'b000000, i_func[1:5]};
            2'b10:   w_word = {i_opcode, i_rs1, i_rs2, i_imm26[10:25]};
            default: w_word = {i_opcode, i_imm26};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= w_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_addr   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_addr   <= r_addr + 32'd4;
                r_count  <= r_count + 16'd1;
            end
            if (w_accept && w_violation) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_addr  <= i_start_addr;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_stop) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_mem_we    = w_mem_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = w_mem_we ? r_fifo[r_rd_ptr[AW-1:0]] : '0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_count     = r_count;
    assign o_err       = r_err;
endmodule

// File: tb/tb_dlx_instr_packer.sv
// tb/tb_dlx_instr_packer.sv - scoreboard bench for dlx_instr_packer
module tb_dlx_instr_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_addr;
    logic        stop;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [25:0] imm26;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic        err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    bit          stall_prev = 0;
    logic [31:0] stall_addr;
    logic [31:0] stall_data;

    dlx_instr_packer #(.DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_start_addr (start_addr),
        .i_stop       (stop),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_fmt        (fmt),
        .i_opcode     (opcode),
        .i_rs1        (rs1),
        .i_rs2        (rs2),
        .i_rd         (rd),
        .i_func       (func),
        .i_imm26      (imm26),
        .o_mem_we     (mem_we),
        .i_mem_ready  (mem_ready),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_count      (count),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [1:0] f, input logic [5:0] op,
                                         input logic [4:0] a, input logic [4:0] b,
                                         input logic [4:0] d, input logic [5:0] fn,
                                         input logic [25:0] imm);
        case (f)
            2'd0: return (32'(a) << 21) | (32'(b) << 16) | (32'(d) << 11) | 32'(fn);
            2'd1: return (32'd1 << 26) | (32'(a) << 21) | (32'(b) << 16) | (32'(d) << 11)
                         | 32'(fn & 6'h1f);
            2'd2: return (32'(op) << 26) | (32'(a) << 21) | (32'(b) << 16) | (32'(imm) & 32'hffff);
            default: return (32'(op) << 26) | 32'(imm);
        endcase
    endfunction

    // Write monitor: every accepted write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_we", mem_we, 1);
                check("stall_addr", mem_addr, stall_addr);
                check("stall_data", mem_wdata, stall_data);
            end
            if (mem_we && mem_ready) begin
                check("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                end
                n_writes++;
            end
            stall_prev = mem_we && !mem_ready;
            stall_addr = mem_addr;
            stall_data = mem_wdata;
        end else begin
            stall_prev = 0;
        end
    end

    task automatic pulse_start(input logic [31:0] a);
        start_addr = a;
        start      = 1'b1;
        exp_addr   = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic [5:0] fn,
                        input logic [25:0] imm, input logic [31:0] word, input bit pushes);
        bit ok = 0;
        fmt = f; opcode = op; rs1 = a; rs2 = b; rd = d; func = fn; imm26 = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check("in_ready_seen", ok, 1);
        if (ok && pushes) begin
            exp_q.push_back('{exp_addr, word});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit pushes_r);
        logic [1:0]  f;
        logic [5:0]  op;
        logic [4:0]  a, b, d;
        logic [5:0]  fn;
        logic [25:0] imm;
        f   = 2'($urandom_range(0, 3));
        op  = 6'($urandom_range(2, 63));
`ifdef PACKER_FMT_CHECK_EN
        if (f == 2'd0) op = 6'd0;
        if (f == 2'd1) op = 6'd1;
`endif
        a   = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
        fn  = 6'($urandom); imm = 26'($urandom);
        send(f, op, a, b, d, fn, imm, pack(f, op, a, b, d, fn, imm), pushes_r);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic window_done(input string tag);
        int ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check({tag, "_busy_with_done"}, busy, 0);
                check({tag, "_in_ready_with_done"}, in_ready, 0);
            end
        end
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_busy_after"}, busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int w0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        start_addr = '0; fmt = '0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
        func = '0; imm26 = '0; exp_addr = '0;
        #23;
        check("rst_mem_we", mem_we, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst", busy, 0);

        // Basic R-type
        mem_ready = 1'b1;
        pulse_start(32'h0000_0100);
        check("busy_run", busy, 1);
        send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 6'h20, 26'd0, 32'h0022_1820, 1);
        wait_empty("drain_r");
        check("count_r", count, 1);

        // I-type then J-type
        send(2'b10, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 26'h000_FFFF, 32'h2022_FFFF, 1);
        send(2'b11, 6'h02, 5'd0, 5'd0, 5'd0, 6'd0, 26'h000_0010, 32'h0800_0010, 1);
        wait_empty("drain_ij");
        check("count_ij", count, 3);

        // Backpressure: fill the FIFO while memory stalls
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(1);
        @(negedge clk);
        check("in_ready_full", in_ready, 0);
        check("mem_we_stalled", mem_we, 1);
        repeat (5) @(negedge clk);
        check("count_stalled", count, 3);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        wait_empty("drain_bp");
        check("count_bp", count, 7);
        pulse_stop();
        window_done("stop1");

        // Address wrap through drain
        pulse_start(32'hFFFF_FFFC);
        check("count_cleared", count, 0);
        mem_ready = 1'b0;
        send(2'b00, 6'd0, 5'd4, 5'd5, 5'd6, 6'h22, 26'd0, 32'h0085_3022, 1);
        send(2'b11, 6'h03, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FF_FFFF, 32'h0FFF_FFFF, 1);
        pulse_stop();
        mem_ready = 1'b1;
        window_done("wrap");
        check("wrap_empty", exp_q.size(), 0);
        check("count_wrap", count, 2);
        check("addr_wrap", mem_addr, 32'h0000_0004);

        // Reset mid-session with three words pending
        pulse_start(32'h0000_0200);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(1);
        check("in_ready_3", in_ready, 1);
        w0 = n_writes;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_mem_we", mem_we, 0);
        check("midrst_count", count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("postrst_count", count, 0);
        check("postrst_busy", busy, 0);
        check("postrst_writes", n_writes, w0);

        // Format handling of a non-R opcode on an R-type beat
        pulse_start(32'h0000_0300);
`ifdef PACKER_FMT_CHECK_EN
        w0 = n_writes;
        send(2'b00, 6'h08, 5'd1, 5'd2, 5'd3, 6'h20, 26'd0, 32'h0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("viol_err", err, 1);
        check("viol_count", count, 0);
        check("viol_writes", n_writes, w0);
        pulse_stop();
        window_done("viol");
        check("err_sticky_idle", err, 1);
        pulse_start(32'h0000_0400);
        check("err_cleared", err, 0);
`else
        send(2'b00, 6'h08, 5'd1, 5'd2, 5'd3, 6'h20, 26'd0, 32'h0022_1820, 1);
        send(2'b01, 6'h3F, 5'd7, 5'd8, 5'd9, 6'h3F, 26'd0, 32'h04E8_481F, 1);
        wait_empty("drain_force");
        check("force_err", err, 0);
        check("force_count", count, 2);
`endif

        // Random traffic with random memory stalls
        for (int i = 0; i < 16; i++) begin
            mem_ready = 1'($urandom);
            send_rand(1);
        end
        mem_ready = 1'b1;
        wait_empty("drain_rand");
        pulse_stop();
        window_done("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dlx_instr_packer.md
DLX_INSTR_PACKER -- requirements
Module: dlx_instr_packer

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries between the field input and the memory write port (power of two, at least 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse that begins a load session.
REQ-005 start_addr  input  [0:31]  first instruction-memory byte address, sampled on an accepted start.
REQ-006 stop  input  1  single-cycle pulse that ends a session after the FIFO drains.
REQ-007 in_valid / in_ready  input / output  1 / 1  field-input handshake.
REQ-008 fmt  input  [0:1]  format select: 00 R-type, 01 FP R-type, 10 I-type, 11 J-type.
REQ-009 opcode [0:5], rs1 [0:4], rs2 [0:4], rd [0:4], func [0:5], imm26 [0:25]  inputs  instruction fields; I-type uses imm26[10:25] as imm16.
REQ-010 mem_we  output  1  write request to instruction memory.
REQ-011 mem_ready  input  1  memory accepts the write in a cycle where mem_we=1.
REQ-012 mem_addr / mem_wdata  outputs  [0:31] / [0:31]  write address and instruction word (bit 0 = MSB).
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 done  output  1  one-cycle pulse when DRAIN completes.
REQ-015 count  output  [0:15]  words written this session; wraps modulo 2^16.
REQ-016 err  output  1  sticky format-violation flag (see Configuration).

Function
REQ-017 States: IDLE, RUN, DRAIN.
REQ-018 IDLE: start -> RUN, loading mem_addr from start_addr and clearing count and err. stop is ignored. If start and stop are both high, start wins and stop is ignored.
REQ-019 RUN: stop -> DRAIN. start is ignored.
REQ-020 DRAIN: when the FIFO is empty and no write is pending, go to IDLE and pulse done for one cycle. start and stop are ignored.
REQ-021 in_ready = (state==RUN) and FIFO not full. An input beat transfers when in_valid and in_ready are both high.
REQ-022 A word pushed in cycle N is visible on mem_wdata with mem_we=1 no earlier than cycle N+1. There is no bypass path.
REQ-023 mem_we = (RUN or DRAIN) and FIFO not empty.
REQ-024 mem_we, mem_addr and mem_wdata shall hold stable while mem_we=1 and mem_ready=0.
REQ-025 On each write transfer: pop the FIFO, increment count, and add 4 to mem_addr, wrapping modulo 2^32.
REQ-026 A push and a pop in the same cycle are both performed and occupancy is unchanged. A push while full cannot occur because in_ready is low.
REQ-027 R-type word layout:
  - [0:5] = 000000
  - [6:10] = rs1, [11:15] = rs2, [16:20] = rd
  - [21:25] = 0
  - [26:31] = func
REQ-028 FP R-type word layout: [0:5] = 000001, register fields as R-type, [21:26] = 0, [27:31] = func[1:5].
REQ-029 I-type word layout: [0:5] = opcode, [6:10] = rs1, [11:15] = rs2 (destination), [16:31] = imm16.
REQ-030 J-type word layout: [0:5] = opcode, [6:31] = imm26.
REQ-031 For each format, input fields that the format does not use shall be ignored.

Reset
REQ-032 While rst_n=0, all of the following hold regardless of clk:
  - state = IDLE
  - FIFO empty
  - mem_we = 0
  - mem_addr = 0, mem_wdata = 0
  - count = 0
  - in_ready = 0, busy = 0, done = 0, err = 0
REQ-033 A reset asserted mid-session discards all FIFO contents and any pending write. No write completes in or after the reset cycle.
REQ-034 After rst_n rises, the block stays in IDLE until the next start.

Configuration
REQ-035 Macro PACKER_FMT_CHECK_EN enables the format check.
REQ-036 With PACKER_FMT_CHECK_EN defined, an accepted beat is a violation if it has fmt=00 with opcode!=000000, fmt=01 with opcode!=000001, or fmt=10/11 with opcode 000000 or 000001.
REQ-037 With PACKER_FMT_CHECK_EN defined, a violating beat is consumed but not pushed, it sets err until the next accepted start or reset, and count is unaffected.
REQ-038 Without PACKER_FMT_CHECK_EN, the opcode for fmt 00/01 is forced per REQ-027/REQ-028, every accepted beat is pushed, and err is tied to 0.

Verification
REQ-039 Basic R-type write: reset; start with start_addr=0x00000100; send fmt=00, rs1=1, rs2=2, rd=3, func=0x20; mem_ready=1. Required: write of 0x00221820 at address 0x100; count=1.
REQ-040 I-type then J-type: send I-type (opcode=0x08, rs1=1, rs2=2, imm16=0xFFFF), then J-type (opcode=0x02, imm26=0x10). Required: 0x2022FFFF at 0x104, then 0x08000010 at 0x108.
REQ-041 Backpressure:
  - hold mem_ready=0 and push DEPTH beats; in_ready must drop after the 4th beat
  - mem_wdata/mem_addr must stay stable while stalled
  - release mem_ready; all 4 words must be written in order at consecutive +4 addresses
REQ-042 Drain and wrap:
  - start_addr=0xFFFFFFFC; push 2 words; pulse stop
  - required: writes at 0xFFFFFFFC then 0x00000000
  - done pulses once; busy falls in the same cycle; state returns to IDLE
REQ-043 Reset mid-session: with 3 entries in the FIFO and mem_ready=0, assert rst_n=0. Required: mem_we=0 immediately; after release, count=0 and no further writes occur until start.
REQ-044 With PACKER_FMT_CHECK_EN defined: send fmt=00 with opcode=0x08. Required: no write, err=1, count unchanged; the next start clears err.
